tenary_conv_ctrl: RTL and testbench
===================================

# tenary_conv_ctrl

Sequencing controller for the ternary 3x3 adder datapath. It walks one output feature map row by row and channel group by channel group. For each step it issues the `fire` strobe, the window coordinates, the border-padding mask and the weight-reload request. It flushes the adder pipeline after the last valid window and reports completion with a one-cycle `done` pulse. It sits between the layer-level scheduler (`start`/`done`) and the adder plus its feature and weight buffers.

## Interface
- `INPUT_SIZE`, 16, feature map width and height in pixels (square map).
- `TI`, 3, input channels consumed per channel group.
- `INPUT_CHANNEL`, 3, total input channels; must be a multiple of `TI`. `ITER = INPUT_CHANNEL/TI`.
- `ADDR_BITS`, 4, width of the row and column indices; must satisfy `2^ADDR_BITS >= INPUT_SIZE`.
- `GRP_BITS`, 4, width of the group index; must satisfy `2^GRP_BITS >= ITER`.
- `PIPE_LAT`, 3, number of flush `fire` cycles issued after the last window.

Ports:
- `clk`  in  1  clock. Single clock domain, all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  layer start request, sampled only in IDLE.
- `in_valid`  in  1  feature and weight buffers can supply the current window this cycle.
- `fire`  out  1  adder advance strobe.
- `w_load`  out  1  fetch the weights of channel group `grp` this cycle.
- `row`  out  ADDR_BITS  output row of the current window.
- `col`  out  ADDR_BITS  output column of the current window.
- `grp`  out  GRP_BITS  current channel group.
- `pad_mask`  out  9  bit `3*(dr+1)+(dc+1)` is 1 when tap (`row+dr`, `col+dc`) lies outside the map, with `dr, dc` in {-1, 0, 1}.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Index loop nesting, innermost first: `col` 0..`INPUT_SIZE-1`, then `grp` 0..`ITER-1`, then `row` 0..`INPUT_SIZE-1`.
- The FSM state and the counters are registered. All outputs are combinational decodes of state and counters.
- FSM states:
  - IDLE: `busy=0`. `start=1` → WLOAD with `row`, `col` and `grp` all cleared to 0.
  - WLOAD: `w_load=1` and `fire=0`, for exactly 1 cycle. Always → RUN.
  - RUN: `fire = in_valid`. Counters advance only on cycles with `fire=1`. While `in_valid=0` the controller stalls with every output and counter held.
    - A fire with `col` below `INPUT_SIZE-1`: `col` increments.
    - A fire at `col = INPUT_SIZE-1` that is not the last window: `col` clears to 0, `grp` advances (wrapping to 0 and incrementing `row` after `ITER-1`), and the FSM goes to WLOAD.
    - A fire at the last window (`row = INPUT_SIZE-1`, `grp = ITER-1`, `col = INPUT_SIZE-1`): the FSM goes to DRAIN.
  - DRAIN: `fire=1` for exactly `PIPE_LAT` cycles, independent of `in_valid`. Then → DONE.
  - DONE: `done=1` for 1 cycle. Always → IDLE.
- `pad_mask` bits:
  - The bits with `dr=-1` are set when `row=0`.
  - The bits with `dr=+1` are set when `row=INPUT_SIZE-1`.
  - The bits with `dc=-1` and `dc=+1` follow the same rule on `col`.
  - `pad_mask` is meaningful only while `fire=1` in RUN. It is 0 in every state other than RUN.
- Outside RUN, `row`, `col` and `grp` hold their last values; they clear only on entry to WLOAD from IDLE.
- `start` is ignored while `busy=1`, and it has no queueing.
- Reset is asynchronous: every state returns to IDLE immediately, including in the middle of a layer. There is no partial-result recovery.

## Timing
- Reset values:
  - `fire`, `w_load`, `busy`, `done`: 0.
  - `pad_mask`: 0.
  - `row`, `col`, `grp`: 0.
- Start latency: `start` is sampled at edge E. `w_load` and `busy` are high in the cycle after E. The first `fire` is possible in the cycle after edge E+1.
- With `in_valid` held at 1:
  - Total cycles = `INPUT_SIZE*ITER*(1+INPUT_SIZE) + PIPE_LAT + 1`, from the cycle after E through the `done` cycle inclusive.
  - The RUN phase issues exactly `INPUT_SIZE*INPUT_SIZE*ITER` fires.
- `in_valid` low in any RUN cycle extends that total by exactly 1 cycle. `in_valid` has no effect in WLOAD, DRAIN or DONE.
- `start` asserted in the `done` cycle is ignored. `start` asserted in the following cycle, when the FSM is in IDLE, is accepted.

## Test plan
- Bench parameters: `INPUT_SIZE=4`, `TI=3`, `INPUT_CHANNEL=6` (`ITER=2`), `PIPE_LAT=3`, `in_valid` tied high.
  - Pulse `start` → `w_load` pulses 8 times, RUN issues 32 fires, then 3 drain fires.
  - `done` is high during the 44th cycle after the start edge.
- Same parameters, check `(row, grp, col)` on successive fires → (0,0,0), (0,0,1), (0,0,2), (0,0,3), (0,1,0), … , (3,1,3). `w_load` appears before each new (row, grp) pair.
- `pad_mask` checks:
  - At (0,·,0) → `pad_mask = 9'b001_001_111`.
  - At (3,·,3) → `pad_mask = 9'b111_100_100`.
  - At (1,·,1) → `pad_mask = 0`.
- Drive `in_valid=0` for 5 cycles in the middle of a row → outputs and counters are frozen and `fire=0`. The sequence resumes with the same (row, grp, col), and `done` arrives 5 cycles later than in the first scenario.
- Pulse `start` again during RUN and during the `done` cycle → no effect. Assert `start` one cycle after `done` → a new layer begins with `w_load` in the next cycle.
- Assert `rst_n=0` mid-RUN → `fire`, `busy` and `w_load` drop immediately and the counters read 0. After release, with no `start`, the block stays in IDLE.

Source files
------------

// File: rtl/tenary_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tenary_conv_ctrl
//
// Sequencing controller for the ternary 3x3 adder datapath. Walks one output
// feature map with col innermost, then channel group, then row. For each
// window it issues the adder advance strobe together with the window
// coordinates and the border-padding mask. Before every new (row, group) pair
// it requests a weight reload. After the last window it flushes the adder
// pipeline and then pulses done for one cycle.
//
// Ports:
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset
//   start     in   1          layer start request, sampled only in IDLE
//   in_valid  in   1          buffers can supply the current window
//   fire      out  1          adder advance strobe
//   w_load    out  1          fetch weights of channel group grp
//   row       out  ADDR_BITS  output row of the current window
//   col       out  ADDR_BITS  output column of the current window
//   grp       out  GRP_BITS   current channel group
//   pad_mask  out  9          bit 3*(dr+1)+(dc+1) set when tap lies off-map
//   busy      out  1          high in every state except IDLE
//   done      out  1          one-cycle completion pulse
// -----------------------------------------------------------------------------
module tenary_conv_ctrl #(
  parameter int INPUT_SIZE    = 16,
  parameter int TI            = 3,
  parameter int INPUT_CHANNEL = 3,
  parameter int ADDR_BITS     = 4,
  parameter int GRP_BITS      = 4,
  parameter int PIPE_LAT      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 fire,
  output logic                 w_load,
  output logic [ADDR_BITS-1:0] row,
  output logic [ADDR_BITS-1:0] col,
  output logic [GRP_BITS-1:0]  grp,
  output logic [8:0]           pad_mask,
  output logic                 busy,
  output logic                 done
);

  localparam int ITER    = INPUT_CHANNEL / TI;
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_BITS-1:0] LAST_POS   = ADDR_BITS'(INPUT_SIZE - 1);
  localparam logic [GRP_BITS-1:0]  LAST_GRP   = GRP_BITS'(ITER - 1);
  localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] row_q, row_d;
  logic [ADDR_BITS-1:0] col_q, col_d;
  logic [GRP_BITS-1:0]  grp_q, grp_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;

  logic last_window_s;
  logic top_s, bot_s, left_s, right_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= {ADDR_BITS{1'b0}};
      col_q   <= {ADDR_BITS{1'b0}};
      grp_q   <= {GRP_BITS{1'b0}};
      drain_q <= {DRAIN_W{1'b0}};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      grp_q   <= grp_d;
      drain_q <= drain_d;
    end
  end

  // Final window of the layer: the fire here ends RUN instead of reloading.
  always_comb begin
    last_window_s = (row_q == LAST_POS) && (grp_q == LAST_GRP) && (col_q == LAST_POS);
  end

  // Next-state, counter update and strobe decode.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    grp_d   = grp_q;
    drain_d = drain_q;
    fire    = 1'b0;
    w_load  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_WLOAD;
          row_d   = {ADDR_BITS{1'b0}};
          col_d   = {ADDR_BITS{1'b0}};
          grp_d   = {GRP_BITS{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WLOAD: begin
        w_load  = 1'b1;
        state_d = S_RUN;
      end

      S_RUN: begin
        // A stalled cycle leaves every counter untouched.
        fire = in_valid;
        if (in_valid) begin
          if (col_q != LAST_POS) begin
            col_d = col_q + ADDR_BITS'(1);
          end else if (last_window_s) begin
            state_d = S_DRAIN;
            drain_d = {DRAIN_W{1'b0}};
          end else begin
            col_d   = {ADDR_BITS{1'b0}};
            state_d = S_WLOAD;
            if (grp_q == LAST_GRP) begin
              grp_d = {GRP_BITS{1'b0}};
              row_d = row_q + ADDR_BITS'(1);
            end else begin
              grp_d = grp_q + GRP_BITS'(1);
            end
          end
        end else begin
          state_d = S_RUN;
        end
      end

      S_DRAIN: begin
        // Flush fires are unconditional: the adder pipeline holds no new data.
        fire = 1'b1;
        if (drain_q == LAST_DRAIN) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Map-border flags for the current window.
  always_comb begin
    top_s   = (row_q == {ADDR_BITS{1'b0}});
    bot_s   = (row_q == LAST_POS);
    left_s  = (col_q == {ADDR_BITS{1'b0}});
    right_s = (col_q == LAST_POS);
  end

  // Padding mask: bits 0-2 are the row above, 6-8 the row below; within each
  // triple bit 0 is the left tap and bit 2 the right tap. Only driven in RUN.
  always_comb begin
    pad_mask = 9'b0_0000_0000;
    if (state_q == S_RUN) begin
      pad_mask[0] = top_s | left_s;
      pad_mask[1] = top_s;
      pad_mask[2] = top_s | right_s;
      pad_mask[3] = left_s;
      pad_mask[4] = 1'b0;
      pad_mask[5] = right_s;
      pad_mask[6] = bot_s | left_s;
      pad_mask[7] = bot_s;
      pad_mask[8] = bot_s | right_s;
    end else begin
      pad_mask = 9'b0_0000_0000;
    end
  end

  // Coordinates are the counter registers themselves.
  always_comb begin
    row = row_q;
    col = col_q;
    grp = grp_q;
  end

endmodule

// File: tb/tb_tenary_conv_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for tenary_conv_ctrl. A reference trace is built per layer from
// nested loops over (row, group, col), with random stalls and random start
// noise inserted, then applied cycle by cycle and compared on every output.
// -----------------------------------------------------------------------------
module tb_tenary_conv_ctrl;

  localparam int N    = 4;
  localparam int TI   = 3;
  localparam int IC   = 6;
  localparam int ITER = IC / TI;
  localparam int PL   = 3;
  localparam int AB   = 4;
  localparam int GB   = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          fire;
  logic          w_load;
  logic [AB-1:0] row;
  logic [AB-1:0] col;
  logic [GB-1:0] grp;
  logic [8:0]    pad_mask;
  logic          busy;
  logic          done;

  tenary_conv_ctrl #(
    .INPUT_SIZE   (N),
    .TI           (TI),
    .INPUT_CHANNEL(IC),
    .ADDR_BITS    (AB),
    .GRP_BITS     (GB),
    .PIPE_LAT     (PL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_valid(in_valid),
    .fire    (fire),
    .w_load  (w_load),
    .row     (row),
    .col     (col),
    .grp     (grp),
    .pad_mask(pad_mask),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          in_valid;
    logic          fire;
    logic          w_load;
    logic          busy;
    logic          done;
    logic [AB-1:0] row;
    logic [AB-1:0] col;
    logic [GB-1:0] grp;
    logic [8:0]    pad;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] pad_log[$];
  int n_tests = 0;
  int n_fail  = 0;
  int hold_r  = 0;
  int hold_c  = 0;
  int hold_g  = 0;
  int seg_done;
  int seg_wl;
  int seg_fire;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Which of the nine taps around (r, c) fall outside the N x N map.
  function automatic logic [8:0] padm(input int r, input int c);
    logic [8:0] m;
    m = 9'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((r + dr < 0) || (r + dr >= N) || (c + dc < 0) || (c + dc >= N)) begin
          m[3 * (dr + 1) + (dc + 1)] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic st, input logic iv, input logic f, input logic wl,
                      input logic b, input logic d, input int r, input int c,
                      input int g, input logic [8:0] pm);
    vec_t v;
    v.start    = st;
    v.in_valid = iv;
    v.fire     = f;
    v.w_load   = wl;
    v.busy     = b;
    v.done     = d;
    v.row      = AB'(r);
    v.col      = AB'(c);
    v.grp      = GB'(g);
    v.pad      = pm;
    tbl.push_back(v);
  endtask

  // One idle cycle; counters show whatever the previous layer left behind.
  task automatic push_idle(input logic st);
    push(st, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, hold_r, hold_c, hold_g, 9'b0);
  endtask

  // Expected trace of one whole layer, starting the cycle after start is taken.
  task automatic build_layer(input int pct, input int stall_win, input int stall_len,
                             input logic noise);
    int w;
    w = 0;
    for (int r = 0; r < N; r++) begin
      for (int g = 0; g < ITER; g++) begin
        push(noise & rbit(), rbit(), 1'b0, 1'b1, 1'b1, 1'b0, r, 0, g, 9'b0);
        for (int c = 0; c < N; c++) begin
          int k;
          k = 0;
          if (w == stall_win) begin
            repeat (stall_len) push(noise & rbit(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r, c, g, padm(r, c));
          end
          while (pct > 0 && k < 4 && $urandom_range(0, 99) < pct) begin
            push(noise & rbit(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r, c, g, padm(r, c));
            k++;
          end
          push(noise & rbit(), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, r, c, g, padm(r, c));
          w++;
        end
      end
    end
    repeat (PL) push(noise & rbit(), rbit(), 1'b1, 1'b0, 1'b1, 1'b0, N - 1, N - 1, ITER - 1, 9'b0);
    push(noise, rbit(), 1'b0, 1'b0, 1'b1, 1'b1, N - 1, N - 1, ITER - 1, 9'b0);
    hold_r = N - 1;
    hold_c = N - 1;
    hold_g = ITER - 1;
  endtask

  // Apply the table one vector per cycle and compare every output.
  task automatic run_table();
    seg_done = -1;
    seg_wl   = 0;
    seg_fire = 0;
    pad_log.delete();
    foreach (tbl[i]) begin
      @(negedge clk);
      start    = tbl[i].start;
      in_valid = tbl[i].in_valid;
      #1;
      check($sformatf("vec%0d {fire,wl,busy,done,row,col,grp,pad}", i),
            {39'd0, fire, w_load, busy, done, row, col, grp, pad_mask},
            {39'd0, tbl[i].fire, tbl[i].w_load, tbl[i].busy, tbl[i].done,
             tbl[i].row, tbl[i].col, tbl[i].grp, tbl[i].pad});
      pad_log.push_back(pad_mask);
      if (done) seg_done = i;
      if (w_load) seg_wl++;
      if (fire) seg_fire++;
    end
    start = 1'b0;
    tbl.delete();
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_state", {39'd0, fire, w_load, busy, done, row, col, grp, pad_mask}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean layer with no stalls: timing, pulse counts and pad corners.
    push_idle(1'b1);
    build_layer(0, -1, 0, 1'b0);
    run_table();
    check("A_done_cycle", 64'(seg_done), 64'd44);
    check("A_wload_count", 64'(seg_wl), 64'd8);
    check("A_fire_count", 64'(seg_fire), 64'd35);
    check("pad_at_0_0", {55'd0, pad_log[2]}, {55'd0, 9'b001_001_111});
    check("pad_at_3_3", {55'd0, pad_log[40]}, {55'd0, 9'b111_100_100});
    check("pad_at_1_1", {55'd0, pad_log[13]}, 64'd0);

    // Five-cycle stall mid-row delays done by exactly five cycles.
    push_idle(1'b1);
    build_layer(0, 6, 5, 1'b0);
    run_table();
    check("B_done_cycle", 64'(seg_done), 64'd49);
    check("B_fire_count", 64'(seg_fire), 64'd35);

    // Random stalls, start noise while busy and in done, back-to-back restart.
    push_idle(1'b1);
    build_layer(30, -1, 0, 1'b1);
    push_idle(1'b1);
    build_layer(30, -1, 0, 1'b1);
    push_idle(1'b0);
    run_table();

    // Several more random layers with idle gaps.
    for (int n = 0; n < 3; n++) begin
      push_idle(1'b0);
      push_idle(1'b1);
      build_layer(20, $urandom_range(0, N * N * ITER - 1), $urandom_range(1, 6), 1'b1);
    end
    run_table();

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("E_pre_reset {fire,busy,wl,row,col,grp}",
          {48'd0, fire, busy, w_load, 1'b0, row, col, grp},
          {48'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1});
    #1 rst_n = 1'b0;
    #1;
    check("E_in_reset", {39'd0, fire, w_load, busy, done, row, col, grp, pad_mask}, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    hold_r = 0;
    hold_c = 0;
    hold_g = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      check("E_idle_after_reset {busy,fire,wl,done}", {60'd0, busy, fire, w_load, done}, 64'd0);
    end

    // The block still starts normally after the reset.
    push_idle(1'b1);
    build_layer(15, -1, 0, 1'b0);
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
